pio_led_fader: RTL and testbench
================================

Name: pio_led_fader

Overview:
- Downstream consumer of the 8-bit LED PIO output register's out_port. Turns each on/off bit into a PWM-driven LED that ramps brightness linearly toward full-on or full-off.
- Sits between the PIO out_port and the board LED pins.
- Software writes patterns only. It needs no knowledge of PWM timing.
- A bypass mode gives a plain registered pass-through.

Parameters:
- N_LEDS, 8, number of LED channels (matches PIO width).
- PWM_BITS, 8, brightness resolution. PWM_MAX = 2^PWM_BITS-1 (255).
- STEP_DIV, 50000, clocks per brightness step. Legal range is 1 to 2^24-1. A full 0→PWM_MAX fade takes PWM_MAX*STEP_DIV clocks.

Ports:
- clk  in  1  system clock, same domain as the PIO.
- reset_n  in  1  asynchronous active-low reset.
- led_in  in  N_LEDS  LED pattern from PIO out_port. Bit=1 means target full-on.
- fade_en  in  1  1 = fade mode, 0 = bypass (snap).
- led_out  out  N_LEDS  registered PWM drive to LED pins.
- busy  out  1  registered. High while any channel level differs from its target.

Behaviour:
- Reset is asynchronous on reset_n low. led_q, every level[i], pwm_cnt, prescaler, led_out and busy all clear to 0.
- Input stage: led_q <= led_in every clock. target[i] = led_q[i] ? PWM_MAX : 0.
- PWM counter: pwm_cnt counts 0..PWM_MAX-1 and wraps to 0, so the period is PWM_MAX clocks.
  - led_out[i] <= (level[i] > pwm_cnt).
  - Level 0 gives constant 0. Level PWM_MAX gives constant 1. Level L gives exactly L high clocks per period.
  - pwm_cnt runs in both modes.
- Prescaler (fade_en=1): counts 0..STEP_DIV-1. step_tick is asserted on the clock it holds STEP_DIV-1, and it wraps to 0 on that clock.
- Prescaler (fade_en=0): held at 0 and step_tick is 0. The first tick after fade_en rises therefore comes STEP_DIV clocks later.
- Level update on step_tick: for each i, level[i] moves by exactly 1 toward target[i]. A channel with level equal to target is unchanged. No overshoot and no wrap, so levels saturate at 0 and PWM_MAX.
- Bypass (fade_en=0): level[i] <= target[i] every clock.
  - Latency from an led_in edge at clock t: led_q at t+1, level at t+2, led_out at t+3.
- Target reversal mid-fade: the ramp direction reverses from the current level at the next tick. Level never jumps.
- fade_en falling mid-fade: levels snap to target on the next clock, and busy clears one clock later.
- busy <= OR over i of (level[i] != target[i]), evaluated on registered values.
- Reset mid-fade: everything returns to reset values immediately, with no glitch other than led_out going low. Operation resumes on the first clock after reset_n deasserts.
- All arithmetic is unsigned PWM_BITS-wide. The comparator is strictly greater-than.

Decomposition:
- Shared package pio_led_pkg holds:
  - PWM_BITS default and PWM_MAX constant;
  - the level_t typedef (logic [PWM_BITS-1:0]);
  - prescaler width constant (24).
- One sub-module, led_fade_channel, instantiated N_LEDS times via generate.
  - Ports: clk, reset_n, target bit, fade_en, step_tick, pwm_cnt.
  - Contents: the level register, step/snap logic, the comparator and the led_out bit.
  - Outputs: led_out bit and per-channel neq flag.
- The top level holds led_q, pwm_cnt, the prescaler, and the busy OR-reduction.

Test Plan:
- Reset: drive reset_n=0 mid-operation with led_in=0xFF and fade_en=0 → led_out=0x00 and busy=0 while reset is low. After release, led_out=0xFF exactly 3 clocks after the first clock edge.
- Bypass latency: fade_en=0, led_in goes 0x00→0xA5 at clock t → led_out=0xA5 at t+3 and stays constant. busy never asserts.
- Fade-up timing: STEP_DIV=4, fade_en=1, led_in 0x00→0x01 → busy rises. level[0] reaches 255 after 255 ticks (≈1020 clocks plus pipeline). busy falls on the following clock. led_out[0] is then constantly 1.
- Duty check: STEP_DIV=4, stop the fade by sampling once level[0]=64 → over any aligned 255-clock PWM period led_out[0] is high for exactly 64 clocks. Other channels stay 0.
- Reversal: fade up to level 100, then led_in 0x01→0x00 → level decrements 100,99,… with no jump. Reaches 0 after 100 more ticks. busy then drops.
- Enable drop: mid-fade at level 50 with target 255, deassert fade_en → level=255 on the next clock and busy=0 one clock later. The prescaler reads 0.

Source files
------------

// File: rtl/pio_led_pkg.sv
// Shared constants and types for the PIO LED fader: brightness width, full-on
// level and prescaler width.
package pio_led_pkg;
  localparam int PWM_BITS = 8;
  localparam int PWM_MAX  = (1 << PWM_BITS) - 1;
  localparam int PRESC_W  = 24;

  typedef logic [PWM_BITS-1:0] level_t;
endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level register that ramps or snaps toward its
// on/off target, and the PWM comparator driving the LED pin.
module led_fade_channel
  import pio_led_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   target,
  input  logic   fade_en,
  input  logic   step_tick,
  input  level_t pwm_cnt,
  output logic   led_out,
  output logic   neq
);

  level_t level;
  level_t level_nxt;
  level_t target_lvl;

  // An on bit maps to all-ones, which is exactly PWM_MAX.
  assign target_lvl = {$bits(level_t){target}};
  assign neq        = (level != target_lvl);

  always_comb begin
    // NOTE: default first so every path assigns level_nxt and no latch is inferred.
    level_nxt = level;
    if (!fade_en) begin
      level_nxt = target_lvl;
    end else if (step_tick && neq) begin
      level_nxt = (level < target_lvl) ? level + 1'b1 : level - 1'b1;
    end
  end

  // NOTE: async reset clears only real state registers; non-blocking (<=) keeps
  // every flop sampling pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level   <= '0;
      led_out <= 1'b0;
    end else begin
      level   <= level_nxt;
      led_out <= (level > pwm_cnt);
    end
  end

endmodule

// File: rtl/pio_led_fader.sv
// PIO LED fader top: registers the PIO pattern, runs the shared PWM counter and
// step prescaler, and fans out to one fade channel per LED.
module pio_led_fader
  import pio_led_pkg::*;
#(
  parameter int N_LEDS   = 8,
  parameter int STEP_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_LEDS-1:0] led_in,
  input  logic              fade_en,
  output logic [N_LEDS-1:0] led_out,
  output logic              busy
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);
  localparam level_t             PWM_LAST   = level_t'(PWM_MAX - 1);

  logic [N_LEDS-1:0]  led_q;
  logic [N_LEDS-1:0]  neq;
  level_t             pwm_cnt;
  logic [PRESC_W-1:0] prescaler;
  logic               step_tick;

  // Prescaler is held at 0 in bypass, so the first tick after enabling fade
  // lands a full STEP_DIV clocks later.
  assign step_tick = fade_en && (prescaler == PRESC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q     <= '0;
      pwm_cnt   <= '0;
      prescaler <= '0;
      busy      <= 1'b0;
    end else begin
      led_q     <= led_in;
      pwm_cnt   <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      prescaler <= (!fade_en || step_tick) ? '0 : prescaler + 1'b1;
      busy      <= |neq;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_fade_channel u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .target    (led_q[i]),
      .fade_en   (fade_en),
      .step_tick (step_tick),
      .pwm_cnt   (pwm_cnt),
      .led_out   (led_out[i]),
      .neq       (neq[i])
    );
  end

endmodule

// File: tb/tb_pio_led_fader.sv
// Self-checking bench for pio_led_fader: a per-cycle reference model feeds a
// scoreboard queue, directed scenarios probe latency, fade timing and reversal.
module tb_pio_led_fader;
  import pio_led_pkg::*;

  localparam int N  = 8;
  localparam int SD = 4;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] led_in  = '0;
  logic         fade_en = 1'b0;
  logic [N-1:0] led_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0] led;
    logic         busy;
  } resp_t;

  resp_t exp_q[$];

  // Reference model state: pattern seen last clock, brightness per LED,
  // clocks since reset and length of the current fade-enabled run.
  logic [N-1:0] m_led_q    = '0;
  int           m_level[N] = '{default: 0};
  longint       m_cyc      = 0;
  int           m_fade_run = 0;

  wire [7:0] lvl0 = dut.g_ch[0].u_ch.level;

  always #5 clk = ~clk;

  pio_led_fader #(.N_LEDS(N), .STEP_DIV(SD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .led_in  (led_in),
    .fade_en (fade_en),
    .led_out (led_out),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_led_q    = '0;
    m_cyc      = 0;
    m_fade_run = 0;
    for (int i = 0; i < N; i++) m_level[i] = 0;
  endtask

  always @(posedge clk or negedge reset_n) begin : model
    resp_t r;
    bit    tick;
    int    tgt;
    if (!reset_n) begin
      model_reset();
    end else begin
      r = '0;
      m_fade_run = fade_en ? m_fade_run + 1 : 0;
      tick = fade_en && ((m_fade_run % SD) == 0);
      for (int i = 0; i < N; i++) begin
        tgt = m_led_q[i] ? PWM_MAX : 0;
        r.led[i] = (m_level[i] > int'(m_cyc % PWM_MAX));
        if (m_level[i] != tgt) r.busy = 1'b1;
        if (!fade_en) m_level[i] = tgt;
        else if (tick && tgt > m_level[i]) m_level[i] = m_level[i] + 1;
        else if (tick && tgt < m_level[i]) m_level[i] = m_level[i] - 1;
      end
      m_led_q = led_in;
      m_cyc   = m_cyc + 1;
      exp_q.push_back(r);
    end
  end

  always @(negedge clk) begin : monitor
    resp_t r;
    if (!reset_n) begin
      check("reset_led_out", 32'(led_out), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      check("sb_led_out", 32'(led_out), 32'(r.led));
      check("sb_busy", 32'(busy), 32'(r.busy));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic measure_latency(input string name, input logic [N-1:0] want);
    int lat = -1;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      step(1);
      if (led_out == want) lat = k;
    end
    check(name, 32'(lat), 32'd3);
  endtask

  task automatic fade_to(input int lvl, input string name);
    bit hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      step(1);
      if (m_level[0] == lvl) hit = 1;
    end
    check(name, 32'(hit), 32'd1);
  endtask

  initial begin
    int bad, prev, maxl, rise, fall, highs, jumps;
    bit done;

    // Reset release with all-on pattern in bypass.
    led_in = 8'hFF;
    step(3);
    reset_n = 1'b1;
    measure_latency("reset_release_latency", 8'hFF);
    step(20);
    reset_n = 1'b0;
    #1;
    check("mid_reset_led_out", 32'(led_out), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(10);

    // Bypass latency and steady output.
    led_in = 8'h00;
    step(5);
    led_in = 8'hA5;
    measure_latency("bypass_latency", 8'hA5);
    bad = 0;
    repeat (300) begin
      step(1);
      if (led_out != 8'hA5 || busy) bad++;
    end
    check("bypass_steady", 32'(bad), 32'd0);

    // Full fade-up of channel 0.
    led_in = 8'h00;
    step(5);
    fade_en = 1'b1;
    led_in  = 8'h01;
    rise = -1;
    fall = -1;
    for (int k = 1; k <= 1300 && fall < 0; k++) begin
      step(1);
      if (busy && rise < 0) rise = k;
      if (!busy && rise >= 0) fall = k;
    end
    check("fade_busy_rise", 32'(rise), 32'd2);
    check("fade_busy_fall", 32'(fall), 32'(PWM_MAX * SD + 1));
    highs = 0;
    bad = 0;
    repeat (PWM_MAX) begin
      step(1);
      if (led_out[0]) highs++;
      if (led_out[N-1:1] != '0) bad++;
    end
    check("full_on_duty", 32'(highs), 32'(PWM_MAX));
    check("others_off", 32'(bad), 32'd0);

    // Reversal at level 100.
    fade_en = 1'b0;
    led_in  = 8'h00;
    step(5);
    fade_en = 1'b1;
    led_in  = 8'h01;
    fade_to(100, "reach_100");
    led_in = 8'h00;
    prev  = int'(lvl0);
    maxl  = prev;
    jumps = 0;
    done  = 0;
    for (int k = 0; k < 700 && !done; k++) begin
      step(1);
      if (int'(lvl0) > prev + 1 || int'(lvl0) + 1 < prev) jumps++;
      if (int'(lvl0) > maxl) maxl = int'(lvl0);
      prev = int'(lvl0);
      if (!busy) done = 1;
    end
    check("reversal_jumps", 32'(jumps), 32'd0);
    check("reversal_peak", 32'(maxl), 32'd100);
    check("reversal_end_level", 32'(lvl0), 32'd0);
    check("reversal_busy_fell", 32'(done), 32'd1);

    // Enable drop mid-fade at level 50.
    fade_en = 1'b0;
    step(5);
    fade_en = 1'b1;
    led_in  = 8'h01;
    fade_to(50, "reach_50");
    fade_en = 1'b0;
    step(1);
    check("drop_snap_level", 32'(lvl0), 32'(PWM_MAX));
    check("drop_prescaler", 32'(dut.prescaler), 32'd0);
    step(1);
    check("drop_busy_clear", 32'(busy), 32'd0);

    // Randomized patterns, modes and occasional resets.
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 9) == 0) begin
        reset_n = 1'b0;
        step($urandom_range(1, 3));
        reset_n = 1'b1;
      end
      led_in  = N'($urandom);
      fade_en = ($urandom_range(0, 3) != 0);
      step($urandom_range(1, 600));
    end

    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
